// File: rtl/difftest_mmio_skip_tracker.sv
// Tags each LSU-retired instruction with the MMIO windows its dcache AR/AW handshakes hit,
// queues the tags in order and presents the head to the difftest probe as io_skip at WB commit.
module difftest_mmio_skip_tracker #(
  parameter int ADDR_W = 64,
  parameter int NREG   = 5,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 32
) (
  input  logic                     clock,
  input  logic                     rst_n,
  input  logic [NREG*ADDR_W-1:0]   reg_base,
  input  logic [NREG*ADDR_W-1:0]   reg_limit,
  input  logic [NREG-1:0]          reg_en,
  input  logic                     ar_valid,
  input  logic                     ar_ready,
  input  logic [ADDR_W-1:0]        ar_addr,
  input  logic                     aw_valid,
  input  logic                     aw_ready,
  input  logic [ADDR_W-1:0]        aw_addr,
  input  logic                     ls_done,
  input  logic                     commit_valid,
  input  logic                     flush,
  output logic                     skip,
  output logic                     skip_is_load,
  output logic                     skip_is_store,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [CNT_W-1:0]         skip_cnt,
  output logic                     err_overflow,
  output logic                     err_underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [NREG-1:0]  ar_match;
  logic [NREG-1:0]  aw_match;
  logic             ld_hit;
  logic             st_hit;
  logic             pend_ld;
  logic             pend_st;
  logic             tag_ld;
  logic             tag_st;
  logic             push;
  logic             pop;
  logic             empty;
  logic             full;
  logic             bypass;
  logic             do_write;
  logic             do_read;
  logic             underflow_evt;
  logic             overflow_evt;
  logic             head_ld;
  logic             head_st;
  logic             out_valid;
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic [DEPTH-1:0] fifo_ld;
  logic [DEPTH-1:0] fifo_st;

  // An empty window (limit <= base) falls out of the compare naturally.
  always_comb begin
    ar_match = '0;
    aw_match = '0;
    for (int i = 0; i < NREG; i++) begin
      ar_match[i] = reg_en[i]
                    && (ar_addr >= reg_base[i*ADDR_W +: ADDR_W])
                    && (ar_addr <  reg_limit[i*ADDR_W +: ADDR_W]);
      aw_match[i] = reg_en[i]
                    && (aw_addr >= reg_base[i*ADDR_W +: ADDR_W])
                    && (aw_addr <  reg_limit[i*ADDR_W +: ADDR_W]);
    end
  end

  always_comb begin
    ld_hit        = ar_valid && ar_ready && (|ar_match);
    st_hit        = aw_valid && aw_ready && (|aw_match);
    tag_ld        = pend_ld || ld_hit;
    tag_st        = pend_st || st_hit;
    push          = ls_done && !flush;
    pop           = commit_valid && !flush;
    empty         = (wr_ptr == rd_ptr);
    full          = (wr_ptr[PTR_W] != rd_ptr[PTR_W])
                    && (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    bypass        = empty && push && pop;
    do_read       = pop && !empty;
    do_write      = push && !bypass && (!full || pop);
    underflow_evt = pop && empty && !push;
    overflow_evt  = push && full && !pop;
  end

  // When empty, the only legal head is the tag arriving this cycle.
  always_comb begin
    head_ld = fifo_ld[rd_ptr[PTR_W-1:0]];
    head_st = fifo_st[rd_ptr[PTR_W-1:0]];
    if (empty) begin
      head_ld = tag_ld;
      head_st = tag_st;
    end
    out_valid     = rst_n && pop && (!empty || push);
    skip_is_load  = out_valid && head_ld;
    skip_is_store = out_valid && head_st;
    skip          = skip_is_load || skip_is_store;
    occupancy     = wr_ptr - rd_ptr;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      pend_ld <= 1'b0;
      pend_st <= 1'b0;
    end else if (ls_done || flush) begin
      pend_ld <= 1'b0;
      pend_st <= 1'b0;
    end else begin
      pend_ld <= pend_ld || ld_hit;
      pend_st <= pend_st || st_hit;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_read)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // On full push+pop the tail slot is the head slot; the head is read before the edge overwrites it.
  always_ff @(posedge clock) begin
    if (do_write && !flush) begin
      fifo_ld[wr_ptr[PTR_W-1:0]] <= tag_ld;
      fifo_st[wr_ptr[PTR_W-1:0]] <= tag_st;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      skip_cnt      <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      if (skip && !(&skip_cnt)) skip_cnt <= skip_cnt + CNT_ONE;
      if (overflow_evt)  err_overflow  <= 1'b1;
      if (underflow_evt) err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_difftest_mmio_skip_tracker.sv
// Directed bench for difftest_mmio_skip_tracker: a queue-based tag model checked every cycle,
// plus hand-computed literal expectations at the interesting points.
module tb_difftest_mmio_skip_tracker;

  localparam int ADDR_W = 64;
  localparam int NREG   = 5;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic                   clock;
  logic                   rst_n;
  logic [NREG*ADDR_W-1:0] reg_base;
  logic [NREG*ADDR_W-1:0] reg_limit;
  logic [NREG-1:0]        reg_en;
  logic                   ar_valid;
  logic                   ar_ready;
  logic [ADDR_W-1:0]      ar_addr;
  logic                   aw_valid;
  logic                   aw_ready;
  logic [ADDR_W-1:0]      aw_addr;
  logic                   ls_done;
  logic                   commit_valid;
  logic                   flush;
  logic                   skip;
  logic                   skip_is_load;
  logic                   skip_is_store;
  logic [$clog2(DEPTH):0] occupancy;
  logic [CNT_W-1:0]       skip_cnt;
  logic                   err_overflow;
  logic                   err_underflow;

  logic [ADDR_W-1:0] base_a  [NREG];
  logic [ADDR_W-1:0] limit_a [NREG];

  int checks_total;
  int checks_passed;

  typedef struct {
    bit ld;
    bit st;
  } tag_t;

  tag_t q[$];
  bit   m_pend_ld;
  bit   m_pend_st;
  int   m_cnt;
  bit   m_ovf;
  bit   m_udf;

  difftest_mmio_skip_tracker #(
    .ADDR_W(ADDR_W), .NREG(NREG), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .rst_n(rst_n),
    .reg_base(reg_base), .reg_limit(reg_limit), .reg_en(reg_en),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr),
    .ls_done(ls_done), .commit_valid(commit_valid), .flush(flush),
    .skip(skip), .skip_is_load(skip_is_load), .skip_is_store(skip_is_store),
    .occupancy(occupancy), .skip_cnt(skip_cnt),
    .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always_comb begin
    reg_base  = '0;
    reg_limit = '0;
    for (int i = 0; i < NREG; i++) begin
      reg_base[i*ADDR_W +: ADDR_W]  = base_a[i];
      reg_limit[i*ADDR_W +: ADDR_W] = limit_a[i];
    end
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks_total++;
    if (actual == expected) checks_passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
  endtask

  function automatic bit in_any(input logic [ADDR_W-1:0] a);
    for (int i = 0; i < NREG; i++)
      if (reg_en[i] && a >= base_a[i] && a < limit_a[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic tag_t incoming_tag();
    tag_t t;
    t.ld = m_pend_ld || (ar_valid && ar_ready && in_any(ar_addr));
    t.st = m_pend_st || (aw_valid && aw_ready && in_any(aw_addr));
    return t;
  endfunction

  // What the commit probe must see this cycle: the oldest queued tag, or the arriving one when empty.
  function automatic tag_t expected_kind();
    tag_t t;
    t.ld = 1'b0;
    t.st = 1'b0;
    if (!rst_n || flush || !commit_valid) return t;
    if (q.size() > 0) t = q[0];
    else if (ls_done) t = incoming_tag();
    return t;
  endfunction

  task automatic model_step();
    tag_t k;
    tag_t inc;
    int   n;
    k = expected_kind();
    if ((k.ld || k.st) && m_cnt < CNT_MAX) m_cnt++;
    if (flush) begin
      q.delete();
    end else begin
      inc = incoming_tag();
      n   = q.size();
      if (commit_valid) begin
        if (n > 0) void'(q.pop_front());
        else if (!ls_done) m_udf = 1'b1;
      end
      if (ls_done && !(n == 0 && commit_valid)) begin
        if (n == DEPTH && !commit_valid) m_ovf = 1'b1;
        else q.push_back(inc);
      end
    end
    if (ls_done || flush) begin
      m_pend_ld = 1'b0;
      m_pend_st = 1'b0;
    end else begin
      m_pend_ld = m_pend_ld || (ar_valid && ar_ready && in_any(ar_addr));
      m_pend_st = m_pend_st || (aw_valid && aw_ready && in_any(aw_addr));
    end
  endtask

  // Inputs change just after the rising edge, so the falling edge sees a settled cycle.
  always @(negedge clock) begin
    tag_t k;
    if (!rst_n) begin
      q.delete();
      m_pend_ld = 1'b0;
      m_pend_st = 1'b0;
      m_cnt = 0;
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end
    k = expected_kind();
    checkOutput("cyc_skip", skip, k.ld || k.st);
    checkOutput("cyc_skip_is_load", skip_is_load, k.ld);
    checkOutput("cyc_skip_is_store", skip_is_store, k.st);
    checkOutput("cyc_occupancy", occupancy, q.size());
    checkOutput("cyc_skip_cnt", skip_cnt, m_cnt);
    checkOutput("cyc_err_overflow", err_overflow, m_ovf);
    checkOutput("cyc_err_underflow", err_underflow, m_udf);
    if (rst_n) model_step();
  end

  task automatic applyStimulus(input bit arv, input logic [ADDR_W-1:0] ara,
                               input bit awv, input logic [ADDR_W-1:0] awa,
                               input bit ls, input bit cv, input bit fl);
    @(posedge clock);
    #1;
    ar_valid     = arv;
    ar_ready     = arv;
    ar_addr      = ara;
    aw_valid     = awv;
    aw_ready     = awv;
    aw_addr      = awa;
    ls_done      = ls;
    commit_valid = cv;
    flush        = fl;
  endtask

  task automatic idle();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic checkKind(input string name, input bit s, input bit l, input bit st);
    #2;
    checkOutput({name, "_skip"}, skip, s);
    checkOutput({name, "_load"}, skip_is_load, l);
    checkOutput({name, "_store"}, skip_is_store, st);
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    base_a[0] = 64'h1000_0000; limit_a[0] = 64'h1000_0008;
    base_a[1] = 64'h2100_0000; limit_a[1] = 64'h2112_C000;
    base_a[2] = 64'h3000_0000; limit_a[2] = 64'h3000_0000;
    base_a[3] = 64'h4000_0000; limit_a[3] = 64'h5000_0000;
    base_a[4] = 64'h6000_0000; limit_a[4] = 64'h5000_0000;
    reg_en = 5'b00111;
    ar_valid = 0; ar_ready = 0; ar_addr = '0;
    aw_valid = 0; aw_ready = 0; aw_addr = '0;
    ls_done = 0; commit_valid = 0; flush = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("reset_occupancy", occupancy, 0);
    checkOutput("reset_skip_cnt", skip_cnt, 0);
    checkOutput("reset_err_overflow", err_overflow, 0);
    repeat (3) @(posedge clock);
    #1 rst_n = 1'b1;

    // Load MMIO hit, retired two cycles later, committed two cycles after that.
    idle();
    applyStimulus(1, 64'h1000_0004, 0, '0, 0, 0, 0);
    idle();
    applyStimulus(0, '0, 0, '0, 1, 0, 0);
    idle();
    applyStimulus(0, '0, 0, '0, 0, 1, 0);
    checkKind("ld_hit", 1, 1, 0);
    idle();
    #2 checkOutput("ld_hit_cnt", skip_cnt, 1);

    // Window edges and a disabled window never match.
    applyStimulus(1, 64'h1000_0008, 0, '0, 0, 0, 0);
    applyStimulus(1, 64'h0FFF_FFFF, 0, '0, 0, 0, 0);
    applyStimulus(0, '0, 0, '0, 1, 0, 0);
    applyStimulus(0, '0, 0, '0, 0, 1, 0);
    checkKind("edge", 0, 0, 0);
    idle();
    reg_en[0] = 1'b0;
    applyStimulus(1, 64'h1000_0000, 0, '0, 1, 0, 0);
    applyStimulus(0, '0, 0, '0, 0, 1, 0);
    checkKind("disabled", 0, 0, 0);
    idle();
    reg_en[0] = 1'b1;

    // Empty-FIFO bypass of a store hit.
    applyStimulus(0, '0, 1, 64'h2100_0000, 1, 1, 0);
    checkKind("bypass", 1, 0, 1);
    checkOutput("bypass_occ", occupancy, 0);
    idle();
    #2 checkOutput("bypass_occ_next", occupancy, 0);
    checkOutput("bypass_cnt", skip_cnt, 2);

    // Overflow with tags ld, none, st, ld+st, ld (the fifth is dropped).
    applyStimulus(1, 64'h1000_0000, 0, '0, 1, 0, 0);
    applyStimulus(0, '0, 0, '0, 1, 0, 0);
    applyStimulus(0, '0, 1, 64'h2100_0010, 1, 0, 0);
    applyStimulus(1, 64'h1000_0007, 1, 64'h2112_BFFF, 1, 0, 0);
    applyStimulus(1, 64'h1000_0000, 0, '0, 1, 0, 0);
    idle();
    #2 checkOutput("ovf_occ", occupancy, 4);
    checkOutput("ovf_flag", err_overflow, 1);
    applyStimulus(0, '0, 0, '0, 0, 1, 0);
    checkKind("drain0", 1, 1, 0);
    applyStimulus(0, '0, 0, '0, 0, 1, 0);
    checkKind("drain1", 0, 0, 0);
    applyStimulus(0, '0, 0, '0, 0, 1, 0);
    checkKind("drain2", 1, 0, 1);
    applyStimulus(0, '0, 0, '0, 0, 1, 0);
    checkKind("drain3", 1, 1, 1);
    idle();
    #2 checkOutput("drain_occ", occupancy, 0);
    checkOutput("drain_cnt", skip_cnt, 5);
    checkOutput("drain_udf", err_underflow, 0);

    // Full FIFO with simultaneous push and pop keeps its level.
    repeat (4) applyStimulus(1, 64'h1000_0000, 0, '0, 1, 0, 0);
    applyStimulus(0, '0, 1, 64'h2100_0000, 1, 1, 0);
    checkKind("full_pp", 1, 1, 0);
    idle();
    #2 checkOutput("full_pp_occ", occupancy, 4);
    repeat (4) applyStimulus(0, '0, 0, '0, 0, 1, 0);
    idle();
    #2 checkOutput("full_pp_cnt", skip_cnt, 10);

    // Flush beats a simultaneous push and pop; the next commit underflows.
    applyStimulus(1, 64'h1000_0000, 0, '0, 1, 0, 0);
    applyStimulus(0, '0, 1, 64'h2100_0000, 1, 0, 0);
    applyStimulus(0, '0, 0, '0, 1, 0, 0);
    applyStimulus(1, 64'h1000_0000, 0, '0, 0, 0, 0);
    applyStimulus(0, '0, 0, '0, 1, 1, 1);
    checkKind("flush", 0, 0, 0);
    idle();
    #2 checkOutput("flush_occ", occupancy, 0);
    applyStimulus(0, '0, 0, '0, 0, 1, 0);
    checkKind("post_flush", 0, 0, 0);
    idle();
    #2 checkOutput("udf_flag", err_underflow, 1);
    checkOutput("udf_ovf_kept", err_overflow, 1);
    applyStimulus(0, '0, 0, '0, 1, 1, 0);
    checkKind("pend_cleared", 0, 0, 0);

    // Saturation of the 4-bit counter.
    repeat (17) applyStimulus(1, 64'h1000_0000, 0, '0, 1, 1, 0);
    idle();
    #2 checkOutput("sat_cnt", skip_cnt, 15);

    // Asynchronous reset in the middle of a skipping commit.
    applyStimulus(1, 64'h1000_0000, 0, '0, 1, 0, 0);
    applyStimulus(1, 64'h1000_0000, 0, '0, 1, 0, 0);
    applyStimulus(0, '0, 0, '0, 0, 1, 0);
    checkKind("pre_rst", 1, 1, 0);
    rst_n = 1'b0;
    #1;
    checkOutput("arst_skip", skip, 0);
    checkOutput("arst_load", skip_is_load, 0);
    checkOutput("arst_occ", occupancy, 0);
    checkOutput("arst_cnt", skip_cnt, 0);
    checkOutput("arst_ovf", err_overflow, 0);
    checkOutput("arst_udf", err_underflow, 0);
    idle();
    @(posedge clock);
    #1 rst_n = 1'b1;
    applyStimulus(1, 64'h1000_0000, 0, '0, 1, 1, 0);
    checkKind("post_rst", 1, 1, 0);
    idle();
    #2 checkOutput("post_rst_cnt", skip_cnt, 1);
    idle();
    idle();

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/difftest_mmio_skip_tracker.md
Name: difftest_mmio_skip_tracker

Overview:
- Parametrised successor to the single-flag MMIO skip logic in the SoC simulation top.
- Watches the dcache AXI AR/AW handshakes against N runtime-programmable address windows.
- Tags each instruction leaving the LSU with load/store MMIO bits and queues the tags in order.
- Presents the queue head to the difftest commit probe as io_skip, aligned with the WB commit.
- Adds over/underflow detection, flush, and a saturating skip counter.

Parameters:
- ADDR_W, 64, address width of AR/AW addresses and window bounds.
- NREG, 5, number of MMIO windows (1..16).
- DEPTH, 4, tag FIFO entries (power of two, >=2).
- CNT_W, 32, width of the skip counter.

Ports:
- clock, input, 1, sole clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- reg_base, input, NREG*ADDR_W, window i inclusive base at bits [i*ADDR_W +: ADDR_W].
- reg_limit, input, NREG*ADDR_W, window i exclusive limit, same packing.
- reg_en, input, NREG, per-window enable.
- ar_valid / ar_ready, input, 1 each, dcache read-address handshake.
- ar_addr, input, ADDR_W, dcache read address.
- aw_valid / aw_ready, input, 1 each, dcache write-address handshake.
- aw_addr, input, ADDR_W, dcache write address.
- ls_done, input, 1, instruction leaves LSU this cycle (LS_EX_execute_ready).
- commit_valid, input, 1, WB commits one instruction this cycle.
- flush, input, 1, pipeline redirect; discard all queued and pending tags.
- skip, output, 1, current commit must be skipped by difftest.
- skip_is_load / skip_is_store, output, 1 each, kind of MMIO access behind skip.
- occupancy, output, $clog2(DEPTH)+1, FIFO fill level.
- skip_cnt, output, CNT_W, saturating count of skipped commits.
- err_overflow / err_underflow, output, 1 each, sticky error flags.

Behaviour:
- Reset: asynchronous, active-low. Clears pend_ld, pend_st, FIFO pointers, occupancy, skip_cnt, and both error flags. All outputs read 0 during reset.
- Window match:
  - hit_i = reg_en[i] && addr >= base_i && addr < limit_i, unsigned compare.
  - limit <= base means the window never matches.
  - ld_hit = ar_valid & ar_ready & OR(hit_i on ar_addr); st_hit is the same on the AW channel.
- Pending bits:
  - pend_ld is set by ld_hit; pend_st is set by st_hit.
  - Both are cleared on a cycle with ls_done (the tag is consumed) or flush.
- Tag formation: on ls_done, tag = {pend_ld|ld_hit, pend_st|st_hit}. A hit in the same cycle as ls_done belongs to this instruction.
- Push: ls_done && !flush writes the tag at the tail.
- Pop: commit_valid && !flush.
  - skip = pop && (head.ld | head.st); skip_is_load/skip_is_store carry the head bits.
  - All three outputs are combinational and 0 when commit_valid=0.
- Empty bypass: FIFO empty with push and pop in the same cycle:
  - Outputs take the incoming tag.
  - Nothing is stored; occupancy stays 0.
  - This is the zero-latency path.
- Underflow: FIFO empty, pop without push. skip=0, err_underflow set; pointers unchanged.
- Overflow: FIFO full, push without pop. Tag dropped, err_overflow set.
- Full FIFO with push and pop in the same cycle is legal; occupancy is unchanged.
- Occupancy = push - pop each cycle, excluding the bypass case.
- Pointers wrap modulo DEPTH; full/empty is detected with an extra wrap bit.
- flush:
  - Next cycle: pointers reset, occupancy 0, pending cleared.
  - Flush wins over push/pop in the same cycle; outputs are 0 that cycle.
  - Error flags and skip_cnt are not affected.
- skip_cnt increments on each cycle with skip=1 and saturates at all-ones.
- Error flags clear only on reset.
- No handshake or LSU back-pressure is generated; the block is a pure observer.

Test Plan:
- Window 0 = [0x1000_0000, 0x1000_0008). ar hit at 0x1000_0004 on cycle 3, ls_done cycle 5, commit cycle 7 -> skip=1, skip_is_load=1, skip_cnt=1.
- ar at 0x1000_0008 (limit) and 0x0FFF_FFFF, then ls_done/commit -> skip=0; with reg_en[0]=0 and addr 0x1000_0000 -> skip=0.
- FIFO empty; aw hit at 0x2100_0000 (window [0x2100_0000,0x2112_C000)) with ls_done and commit_valid in the same cycle -> skip=1, skip_is_store=1, occupancy stays 0.
- DEPTH=4: five ls_done with tags {ld, none, st, ld+st, ld}, no commits -> occupancy=4, err_overflow=1; four commits -> skip sequence 1,0,1,1 with kinds matching the first four tags.
- Three tags queued, flush asserted together with ls_done and commit_valid -> skip=0 that cycle, occupancy=0 next cycle; following commit -> skip=0, err_underflow=1.
- CNT_W=4: 17 MMIO-skipped commits -> skip_cnt=15. Assert rst_n=0 mid-stream -> all outputs 0 immediately, without waiting for a clock edge.
